// File: rtl/md_sequencer.sv
// Multi-cycle mult/div sequencer for the E stage: computes HI/LO at launch, then
// holds busy for a fixed architectural latency before committing the result.
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  opt,
    input  logic [31:0] v1,
    input  logic [31:0] v2,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE,
        RUN
    } SeqState;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    SeqState     state;
    logic [3:0]  count;
    logic [31:0] pendHi;
    logic [31:0] pendLo;
    logic        pendValid;

    logic [63:0] sProd;
    logic [63:0] uProd;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] magBSafe;
    logic [31:0] uDivisor;
    logic [31:0] mQuot;
    logic [31:0] mRem;
    logic [31:0] sQuot;
    logic [31:0] sRem;
    logic [31:0] uQuot;
    logic [31:0] uRem;

    // Signed results are built from magnitudes so 0x80000000 / -1 falls out
    // naturally as quotient 0x80000000, remainder 0.
    assign sProd    = {{32{v1[31]}}, v1} * {{32{v2[31]}}, v2};
    assign uProd    = {32'b0, v1} * {32'b0, v2};
    assign magA     = v1[31] ? (32'd0 - v1) : v1;
    assign magB     = v2[31] ? (32'd0 - v2) : v2;
    assign magBSafe = (v2 == 32'd0) ? 32'd1 : magB;
    assign uDivisor = (v2 == 32'd0) ? 32'd1 : v2;
    assign mQuot    = magA / magBSafe;
    assign mRem     = magA % magBSafe;
    assign sQuot    = (v1[31] ^ v2[31]) ? (32'd0 - mQuot) : mQuot;
    assign sRem     = v1[31] ? (32'd0 - mRem) : mRem;
    assign uQuot    = v1 / uDivisor;
    assign uRem     = v1 % uDivisor;

    logic [31:0] calcHi;
    logic [31:0] calcLo;
    logic        calcValid;
    logic        isMulDiv;
    logic [3:0]  loadCount;

    // A zero divisor still occupies the full divide latency but leaves HI/LO alone.
    always_comb begin
        calcHi    = '0;
        calcLo    = '0;
        calcValid = 1'b0;
        isMulDiv  = 1'b0;
        loadCount = '0;
        case (opt)
            OP_MULT: begin
                {calcHi, calcLo} = sProd;
                calcValid        = 1'b1;
                isMulDiv         = 1'b1;
                loadCount        = MULT_LOAD;
            end
            OP_MULTU: begin
                {calcHi, calcLo} = uProd;
                calcValid        = 1'b1;
                isMulDiv         = 1'b1;
                loadCount        = MULT_LOAD;
            end
            OP_DIV: begin
                calcHi    = sRem;
                calcLo    = sQuot;
                calcValid = (v2 != 32'd0);
                isMulDiv  = 1'b1;
                loadCount = DIV_LOAD;
            end
            OP_DIVU: begin
                calcHi    = uRem;
                calcLo    = uQuot;
                calcValid = (v2 != 32'd0);
                isMulDiv  = 1'b1;
                loadCount = DIV_LOAD;
            end
            default: ;
        endcase
    end

    // HI/LO only ever change on a move or on the commit edge of a mult/div;
    // starts arriving while RUN are dropped since the hazard unit stalls them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            pendHi    <= '0;
            pendLo    <= '0;
            pendValid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (isMulDiv) begin
                            pendHi    <= calcHi;
                            pendLo    <= calcLo;
                            pendValid <= calcValid;
                            count     <= loadCount;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end else if (opt == OP_MTHI) begin
                            hi <= v1;
                        end else if (opt == OP_MTLO) begin
                            lo <= v1;
                        end
                    end
                end
                RUN: begin
                    if (count == 4'd1) begin
                        if (pendValid) begin
                            hi <= pendHi;
                            lo <= pendLo;
                        end
                        count <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed scenarios then random traffic, every cycle
// compared against a timeline-based reference model of HI/LO and busy/done.
module tb_md_sequencer;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  opt = 3'b000;
    logic [31:0] v1 = '0;
    logic [31:0] v2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] mHi, mLo, pHi, pLo;
    logic        mBusy, mDone, pValid;
    int          edgeCount = 0;
    int          commitEdge = 0;

    md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .opt  (opt),
        .v1   (v1),
        .v2   (v2),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", tag, actual, expected, edgeCount);
        end
    endtask

    // Architectural result of one op, from plain integer arithmetic.
    task automatic refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] rHi, output logic [31:0] rLo, output logic rValid);
        longint          sp;
        longint unsigned up, ua, ub;
        int              sa, sb;
        rHi = '0;
        rLo = '0;
        rValid = 1'b1;
        sa = a;
        sb = b;
        case (op)
            OP_MULT: begin
                sp = longint'(sa) * longint'(sb);
                rHi = sp[63:32];
                rLo = sp[31:0];
            end
            OP_MULTU: begin
                ua = a;
                ub = b;
                up = ua * ub;
                rHi = up[63:32];
                rLo = up[31:0];
            end
            OP_DIV: begin
                if (sb == 0) rValid = 1'b0;
                else if (a == 32'h8000_0000 && sb == -1) begin
                    rLo = 32'h8000_0000;
                    rHi = 32'h0;
                end else begin
                    rLo = sa / sb;
                    rHi = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) rValid = 1'b0;
                else begin
                    rLo = a / b;
                    rHi = a % b;
                end
            end
        endcase
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic applyStimulus(input logic rst, input logic st, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        logic wasBusy;
        reset = rst;
        start = st;
        opt   = op;
        v1    = a;
        v2    = b;
        @(posedge clk);
        edgeCount++;
        if (rst) begin
            mHi = '0; mLo = '0; mBusy = 1'b0; mDone = 1'b0; pValid = 1'b0;
        end else begin
            wasBusy = mBusy;
            mDone = 1'b0;
            if (wasBusy && edgeCount == commitEdge) begin
                if (pValid) begin
                    mHi = pHi;
                    mLo = pLo;
                end
                mDone = 1'b1;
                mBusy = 1'b0;
            end else if (!wasBusy && st) begin
                if (op <= OP_DIVU) begin
                    refResult(op, a, b, pHi, pLo, pValid);
                    mBusy = 1'b1;
                    commitEdge = edgeCount + ((op <= OP_MULTU) ? MULT_N : DIV_N);
                end else if (op == OP_MTHI) mHi = a;
                else if (op == OP_MTLO) mLo = a;
            end
        end
        #1;
        checkOutput("busy", {31'b0, busy}, {31'b0, mBusy});
        checkOutput("done", {31'b0, done}, {31'b0, mDone});
        checkOutput("hi", hi, mHi);
        checkOutput("lo", lo, mLo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, OP_MULT, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] pickOperand();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'(int'($urandom_range(0, 20)) - 10);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        mHi = '0; mLo = '0; pHi = '0; pLo = '0;
        mBusy = 1'b0; mDone = 1'b0; pValid = 1'b0;

        // Reset wins over a simultaneous start.
        applyStimulus(1'b1, 1'b1, OP_MTHI, 32'hAAAA_5555, 32'h0);
        applyStimulus(1'b1, 1'b0, OP_MULT, 32'h0, 32'h0);
        checkOutput("resetHi", hi, 32'h0);
        checkOutput("resetBusy", {31'b0, busy}, 32'h0);

        applyStimulus(1'b0, 1'b1, OP_MULT, 32'hFFFF_FFFD, 32'd5);
        idle(MULT_N);
        checkOutput("multHi", hi, 32'hFFFF_FFFF);
        checkOutput("multLo", lo, 32'hFFFF_FFF1);
        checkOutput("multDone", {31'b0, done}, 32'h1);
        idle(1);
        checkOutput("multDoneOnce", {31'b0, done}, 32'h0);

        applyStimulus(1'b0, 1'b1, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(MULT_N);
        checkOutput("multuHi", hi, 32'hFFFF_FFFE);
        checkOutput("multuLo", lo, 32'h0000_0001);

        applyStimulus(1'b0, 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        idle(DIV_N);
        checkOutput("divLo", lo, 32'hFFFF_FFFD);
        checkOutput("divHi", hi, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, OP_DIVU, 32'd1234, 32'd0);
        idle(DIV_N);
        checkOutput("div0Done", {31'b0, done}, 32'h1);
        checkOutput("div0Lo", lo, 32'hFFFF_FFFD);

        applyStimulus(1'b0, 1'b1, OP_MTHI, 32'h1234_5678, 32'h0);
        checkOutput("mthi", hi, 32'h1234_5678);
        applyStimulus(1'b0, 1'b1, OP_MTLO, 32'h9ABC_DEF0, 32'h0);
        checkOutput("mtlo", lo, 32'h9ABC_DEF0);
        applyStimulus(1'b0, 1'b1, OP_MULT, 32'd2, 32'd3);
        idle(1);
        applyStimulus(1'b0, 1'b1, OP_MTLO, 32'h0000_DEAD, 32'h0);
        idle(MULT_N - 2);
        checkOutput("ignoredLo", lo, 32'd6);
        checkOutput("ignoredHi", hi, 32'd0);

        applyStimulus(1'b0, 1'b1, OP_MULT, 32'd4, 32'd4);
        idle(MULT_N);
        checkOutput("gapBusy", {31'b0, busy}, 32'h0);
        checkOutput("b2bFirstLo", lo, 32'd16);
        applyStimulus(1'b0, 1'b1, OP_MULTU, 32'd3, 32'd3);
        checkOutput("b2bBusy", {31'b0, busy}, 32'h1);
        idle(MULT_N);
        checkOutput("b2bLo", lo, 32'd9);

        applyStimulus(1'b0, 1'b1, OP_DIV, 32'd100, 32'd7);
        idle(3);
        applyStimulus(1'b1, 1'b0, OP_MULT, 32'h0, 32'h0);
        checkOutput("abortBusy", {31'b0, busy}, 32'h0);
        checkOutput("abortLo", lo, 32'h0);
        idle(DIV_N + 2);
        checkOutput("abortNoCommit", lo, 32'h0);

        // Random traffic, including starts while busy and occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic rst, st;
            rst = ($urandom_range(0, 79) == 0);
            st  = ($urandom_range(0, 2) == 0);
            applyStimulus(rst, st, 3'($urandom_range(0, 7)), pickOperand(), pickOperand());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide sequencer for the E stage of the five-stage MIPS pipeline. It accepts one HI/LO operation per start pulse and holds the committed HI/LO registers. It models the fixed architectural latency of mult/div with a down-counter and exposes `busy` so the D-stage hazard logic can stall mfhi/mflo/mthi/mtlo and further mult/div. It returns committed HI/LO values to the E-stage result mux.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: E-stage instruction is an HI/LO-writing op; sampled at the rising edge.
- `opt` input 3: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved.
- `v1` input 32: rs operand (dividend / multiplicand / mthi-mtlo source).
- `v2` input 32: rt operand (divisor / multiplier).
- `busy` output 1: a mult/div is in flight.
- `done` output 1: one-cycle pulse in the first cycle after a mult/div commits.
- `hi` output 32: committed HI register.
- `lo` output 32: committed LO register.

## Operation
- States:
  - IDLE: no mult/div in flight.
  - RUN: a mult/div is in flight.
- Result registers (64 bits) and a 4-bit counter.
- In IDLE, when `start` is sampled high:
  - mult/multu/div/divu:
    - compute the result from `v1`/`v2` at that edge and latch it into the result registers;
    - load the counter with `MULT_CYCLES` or `DIV_CYCLES`;
    - go to RUN.
  - mthi: write `hi` = `v1` at that edge; stay in IDLE. `busy` stays 0.
  - mtlo: write `lo` = `v1` at that edge; stay in IDLE. `busy` stays 0.
  - reserved `opt`: no effect.
- In RUN:
  - the counter decrements each cycle;
  - in the cycle where counter == 1, the next edge copies the result registers into `hi`/`lo` and returns to IDLE.
- `start` sampled while in RUN is ignored. Hazard logic must stall these instructions; the block does not queue them.
- Arithmetic:
  - mult: signed 32x32 -> 64; `hi` = product[63:32], `lo` = product[31:0].
  - multu: unsigned 32x32 -> 64; same split as mult.
  - div: signed; `lo` = quotient truncated toward zero; `hi` = remainder with the sign of the dividend.
  - divu: unsigned; `lo` = quotient, `hi` = remainder.
  - div with 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0.
  - divisor == 0 (div or divu): the full `DIV_CYCLES` busy period still elapses; on commit `hi`/`lo` keep their previous values; `done` still pulses.
- `hi`/`lo` show only committed values. During RUN they hold the pre-operation contents.
- Reset: `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, counter = 0, state IDLE. Reset during RUN aborts the operation; no commit occurs.

## Timing
- Cycle 0 is the cycle in which `start` is high with a mult/div opcode. The edge at the end of cycle 0 launches the operation.
- `busy` is 1 during cycles 1..N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- The edge at the end of cycle N commits `hi`/`lo`.
- In cycle N+1: `busy` = 0, `done` = 1, and `hi`/`lo` show the new values.
- `busy` is a registered output. It is 0 in cycle 0, so the hazard unit must OR `start` with `busy` when stalling.
- A new `start` in cycle N+1 is accepted; back-to-back operations have zero idle gap.
- mthi/mtlo: new value visible in cycle 1; `busy` and `done` stay 0.
- Simultaneous reset and `start`: reset wins; nothing is latched.

## Test plan
- Signed mult:
  - stimulus: after reset, mult with `v1` = 0xFFFFFFFD (-3), `v2` = 5;
  - required: `busy` high exactly 5 cycles; in cycle 6 `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1, `done` = 1 for one cycle.
- Unsigned mult:
  - stimulus: multu with `v1` = `v2` = 0xFFFFFFFF;
  - required: `hi` = 0xFFFFFFFE, `lo` = 0x00000001; `hi`/`lo` hold their old values through all 5 busy cycles.
- Signed divide, then divide by zero:
  - stimulus 1: div with `v1` = 0xFFFFFFF9 (-7), `v2` = 2;
  - required: `busy` high 10 cycles, then `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - stimulus 2: divu with `v2` = 0;
  - required: 10 busy cycles, `hi`/`lo` unchanged, `done` pulses.
- Move and ignore-while-busy:
  - stimulus: mthi 0x12345678, mtlo 0x9ABCDEF0, then mult 2x3 with mtlo 0xDEAD asserted during cycle 2;
  - required: the moves are visible one cycle after each; `busy` never asserts for the moves; the mtlo is ignored; final `lo` = 6, `hi` = 0.
- Back-to-back and reset mid-operation:
  - stimulus 1: mult 4x4, with multu 3x3 started in the `done` cycle;
  - required: `busy` has a one-cycle gap; the final commit gives `lo` = 9.
  - stimulus 2: div 100/7 with reset asserted in busy cycle 4;
  - required: the next cycle shows `busy` = 0, `done` = 0, `hi` = `lo` = 0, and no later commit occurs.
